// File: rtl/feature_vector_serializer.sv
// rtl/feature_vector_serializer.sv - captures a 27-feature vector and streams it as 32-bit words (optional FEATURE_CHECKSUM_EN appends an XOR word)
module feature_vector_serializer #(
   parameter int FRAME_ID_W   = 8,
   parameter int NUM_FEATURES = 27
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  feat_valid,
   input  logic [31:0]           psd_delta,
   input  logic [31:0]           psd_theta,
   input  logic [31:0]           psd_alpha,
   input  logic [31:0]           psd_beta,
   input  logic [31:0]           psd_gamma,
   input  logic [31:0]           peak_amplitude,
   input  logic [7:0]            zero_counter,
   input  logic [31:0]           dwt_delta_max,
   input  logic [31:0]           dwt_delta_min,
   input  logic [31:0]           dwt_delta_mean,
   input  logic [31:0]           dwt_delta_sum,
   input  logic [31:0]           dwt_theta_max,
   input  logic [31:0]           dwt_theta_min,
   input  logic [31:0]           dwt_theta_mean,
   input  logic [31:0]           dwt_theta_sum,
   input  logic [31:0]           dwt_alpha_max,
   input  logic [31:0]           dwt_alpha_min,
   input  logic [31:0]           dwt_alpha_mean,
   input  logic [31:0]           dwt_alpha_sum,
   input  logic [31:0]           dwt_beta_max,
   input  logic [31:0]           dwt_beta_min,
   input  logic [31:0]           dwt_beta_mean,
   input  logic [31:0]           dwt_beta_sum,
   input  logic [31:0]           dwt_gamma_max,
   input  logic [31:0]           dwt_gamma_min,
   input  logic [31:0]           dwt_gamma_mean,
   input  logic [31:0]           dwt_gamma_sum,
   output logic [31:0]           out_data,
   output logic [4:0]            out_index,
   output logic [FRAME_ID_W-1:0] out_frame_id,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  overrun
);

`ifdef FEATURE_CHECKSUM_EN
   localparam int NUM_WORDS = NUM_FEATURES + 1;
`else
   localparam int NUM_WORDS = NUM_FEATURES;
`endif
   localparam logic [4:0]            LAST_IDX = 5'(NUM_WORDS - 1);
   localparam logic [FRAME_ID_W-1:0] FID_ONE  = FRAME_ID_W'(1);

   typedef enum logic [0:0] {IDLE, STREAM} state_t;

   state_t                state_q, state_d;
   logic [4:0]            idx_q, idx_d;
   logic [FRAME_ID_W-1:0] fid_q, fid_d;
   logic                  ovr_q, ovr_d;
   logic                  feat_valid_d;
   logic                  load;
   logic                  capture;
   logic                  xfer;
   logic                  is_last;
   logic [31:0]           word_sel;
   logic [31:0]           in_words [NUM_FEATURES];
   logic [31:0]           bank     [NUM_FEATURES];

   assign in_words[0]  = psd_delta;
   assign in_words[1]  = psd_theta;
   assign in_words[2]  = psd_alpha;
   assign in_words[3]  = psd_beta;
   assign in_words[4]  = psd_gamma;
   assign in_words[5]  = peak_amplitude;
   assign in_words[6]  = {24'd0, zero_counter};
   assign in_words[7]  = dwt_delta_max;
   assign in_words[8]  = dwt_delta_min;
   assign in_words[9]  = dwt_delta_mean;
   assign in_words[10] = dwt_delta_sum;
   assign in_words[11] = dwt_theta_max;
   assign in_words[12] = dwt_theta_min;
   assign in_words[13] = dwt_theta_mean;
   assign in_words[14] = dwt_theta_sum;
   assign in_words[15] = dwt_alpha_max;
   assign in_words[16] = dwt_alpha_min;
   assign in_words[17] = dwt_alpha_mean;
   assign in_words[18] = dwt_alpha_sum;
   assign in_words[19] = dwt_beta_max;
   assign in_words[20] = dwt_beta_min;
   assign in_words[21] = dwt_beta_mean;
   assign in_words[22] = dwt_beta_sum;
   assign in_words[23] = dwt_gamma_max;
   assign in_words[24] = dwt_gamma_min;
   assign in_words[25] = dwt_gamma_mean;
   assign in_words[26] = dwt_gamma_sum;

   assign capture = feat_valid & ~feat_valid_d & en;
   assign xfer    = out_valid & out_ready;
   assign is_last = (idx_q == LAST_IDX);

`ifdef FEATURE_CHECKSUM_EN
   logic [31:0] checksum;

   // XOR of every captured feature word, presented as the trailing word
   always_comb begin
      checksum = '0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
         checksum = checksum ^ bank[i];
      end
   end

   assign word_sel = is_last ? checksum : bank[idx_q];
`else
   assign word_sel = bank[idx_q];
`endif

   // Next-state logic: capture, beat advance, frame wrap, abort and overrun flagging
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      fid_d   = fid_q;
      ovr_d   = ovr_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d = STREAM;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         STREAM: begin
            if (!en) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (xfer && is_last) begin
               fid_d = fid_q + FID_ONE;
               idx_d = '0;
               if (capture) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (xfer) begin
                  idx_d = idx_q + 5'd1;
               end
               if (capture) begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state registers and input edge detector
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         fid_q        <= '0;
         ovr_q        <= 1'b0;
         feat_valid_d <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         fid_q        <= fid_d;
         ovr_q        <= ovr_d;
         feat_valid_d <= feat_valid;
      end
   end

   // Feature bank holds the vector stable while it drains
   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < NUM_FEATURES; i++) begin
            bank[i] <= in_words[i];
         end
      end
   end

   assign out_valid    = (state_q == STREAM);
   assign busy         = out_valid;
   assign out_index    = idx_q;
   assign out_frame_id = fid_q;
   assign out_last     = out_valid & is_last;
   assign out_data     = out_valid ? word_sel : 32'd0;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_feature_vector_serializer.sv
// tb/tb_feature_vector_serializer.sv - scoreboard bench for feature_vector_serializer
module tb_feature_vector_serializer;
   localparam int FRAME_ID_W = 8;
`ifdef FEATURE_CHECKSUM_EN
   localparam int NW = 28;
`else
   localparam int NW = 27;
`endif

   typedef struct {
      logic [31:0] data;
      logic [4:0]  idx;
      logic [7:0]  fid;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic feat_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [31:0] vec [27];
   logic [31:0] out_data;
   logic [4:0]  out_index;
   logic [FRAME_ID_W-1:0] out_frame_id;
   logic out_valid, out_last, busy, overrun;

   beat_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   logic [7:0] model_fid = 8'd0;

   always #5 clk = ~clk;

   feature_vector_serializer #(.FRAME_ID_W(FRAME_ID_W), .NUM_FEATURES(27)) dut (
      .clk(clk), .rst(rst), .en(en), .feat_valid(feat_valid),
      .psd_delta(vec[0]), .psd_theta(vec[1]), .psd_alpha(vec[2]), .psd_beta(vec[3]), .psd_gamma(vec[4]),
      .peak_amplitude(vec[5]), .zero_counter(vec[6][7:0]),
      .dwt_delta_max(vec[7]), .dwt_delta_min(vec[8]), .dwt_delta_mean(vec[9]), .dwt_delta_sum(vec[10]),
      .dwt_theta_max(vec[11]), .dwt_theta_min(vec[12]), .dwt_theta_mean(vec[13]), .dwt_theta_sum(vec[14]),
      .dwt_alpha_max(vec[15]), .dwt_alpha_min(vec[16]), .dwt_alpha_mean(vec[17]), .dwt_alpha_sum(vec[18]),
      .dwt_beta_max(vec[19]), .dwt_beta_min(vec[20]), .dwt_beta_mean(vec[21]), .dwt_beta_sum(vec[22]),
      .dwt_gamma_max(vec[23]), .dwt_gamma_min(vec[24]), .dwt_gamma_mean(vec[25]), .dwt_gamma_sum(vec[26]),
      .out_data(out_data), .out_index(out_index), .out_frame_id(out_frame_id),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .overrun(overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pat_vec();
      for (int k = 0; k < 27; k++) vec[k] = 32'(k + 1);
   endtask

   task automatic rand_vec();
      for (int k = 0; k < 27; k++) vec[k] = $urandom;
      vec[6] = {24'd0, 8'($urandom)};
   endtask

   // Reference: the frame is the vector in order, zero_counter zero-extended, plus optional XOR word
   task automatic push_frame();
      beat_t b;
      logic [31:0] x;
      x = 32'd0;
      for (int k = 0; k < NW; k++) begin
         if (k < 27) begin
            b.data = (k == 6) ? {24'd0, vec[6][7:0]} : vec[k];
            x = x ^ b.data;
         end else begin
            b.data = x;
         end
         b.idx  = 5'(k);
         b.fid  = model_fid;
         b.last = (k == NW - 1);
         exp_q.push_back(b);
      end
      model_fid = model_fid + 8'd1;
   endtask

   task automatic pulse();
      feat_valid = 1'b1;
      step(1);
      feat_valid = 1'b0;
   endtask

   task automatic wait_idx(input int idx);
      int t;
      t = 0;
      while (!(out_valid && out_index == 5'(idx)) && t < 200) begin
         step(1);
         t++;
      end
      if (t >= 200) check("wait_idx_timeout", 32'(t), 32'(idx));
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (out_valid && t < 400) begin
         step(1);
         t++;
      end
      if (t >= 400) check("wait_idle_timeout", 32'(t), 32'd0);
   endtask

   // Monitor: pops the scoreboard on every accepted beat and checks hold under backpressure
   initial begin
      beat_t b;
      logic stall;
      logic [31:0] h_data;
      logic [4:0] h_idx;
      logic [7:0] h_fid;
      stall = 1'b0;
      h_data = '0; h_idx = '0; h_fid = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               n_vec++;
               if (!out_valid || out_data !== h_data || out_index !== h_idx || out_frame_id !== h_fid) begin
                  n_err++;
                  $display("FAIL hold: got v=%b d=%h i=%0d f=%0d expected d=%h i=%0d f=%0d",
                           out_valid, out_data, out_index, out_frame_id, h_data, h_idx, h_fid);
               end
            end
            stall  = out_valid && !out_ready;
            h_data = out_data; h_idx = out_index; h_fid = out_frame_id;
            if (out_valid && out_ready && en) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_beat: got i=%0d d=%h expected no beat", out_index, out_data);
               end else begin
                  b = exp_q.pop_front();
                  if (out_data !== b.data || out_index !== b.idx || out_frame_id !== b.fid || out_last !== b.last) begin
                     n_err++;
                     $display("FAIL beat: got d=%h i=%0d f=%0d l=%b expected d=%h i=%0d f=%0d l=%b",
                              out_data, out_index, out_frame_id, out_last, b.data, b.idx, b.fid, b.last);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      for (int k = 0; k < 27; k++) vec[k] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", {28'd0, out_valid, out_last, busy, overrun}, 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_index", {27'd0, out_index}, 32'd0);
      check("rst_fid", {24'd0, out_frame_id}, 32'd0);
      rst = 1'b0;
      en = 1'b1;
      out_ready = 1'b1;

      // Basic capture with k+1 pattern, latency of one cycle
      pat_vec();
      step(2);
      check("pre_valid", {31'd0, out_valid}, 32'd0);
      push_frame();
      pulse();
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_index", {27'd0, out_index}, 32'd0);
      check("lat_busy", {31'd0, busy}, 32'd1);
      wait_idle();
      check("basic_busy_drop", {31'd0, busy}, 32'd0);

      // Backpressure: ready alternates, frame occupies 2*NW cycles
      rand_vec();
      push_frame();
      pulse();
      out_ready = 1'b0;
      cnt = 1;
      while (cnt < 200) begin
         step(1);
         if (!out_valid) break;
         cnt++;
         out_ready = ~out_ready;
      end
      check("bp_cycles", 32'(cnt), 32'(2 * NW));
      out_ready = 1'b1;
      step(2);

      // Coincident capture on every last beat, 257 frames, ids wrap
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      model_fid = 8'd0;
      rand_vec();
      push_frame();
      pulse();
      for (int f = 0; f < 256; f++) begin
         wait_idx(NW - 1);
         rand_vec();
         push_frame();
         pulse();
      end
      wait_idle();
      check("coin_overrun", {31'd0, overrun}, 32'd0);
      check("coin_fid_after_wrap", {24'd0, out_frame_id}, {24'd0, model_fid});

      // Overrun: second edge mid-frame is dropped and flagged
      rand_vec();
      push_frame();
      pulse();
      wait_idx(10);
      rand_vec();
      pulse();
      wait_idle();
      step(5);
      check("ovr_no_second", {31'd0, out_valid}, 32'd0);
      check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      rand_vec();
      push_frame();
      pulse();
      wait_idle();
      check("ovr_sticky", {31'd0, overrun}, 32'd1);

      // Abort via en low: frame id not advanced
      rand_vec();
      push_frame();
      pulse();
      wait_idx(5);
      en = 1'b0;
      step(1);
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      model_fid = model_fid - 8'd1;
      en = 1'b1;
      step(1);
      rand_vec();
      push_frame();
      pulse();
      wait_idle();

      // Reset mid-frame clears everything including overrun
      rand_vec();
      push_frame();
      pulse();
      wait_idx(12);
      rst = 1'b1;
      step(1);
      check("midrst_flags", {28'd0, out_valid, out_last, busy, overrun}, 32'd0);
      check("midrst_data", out_data, 32'd0);
      check("midrst_idx_fid", {19'd0, out_index, out_frame_id}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      model_fid = 8'd0;
      rand_vec();
      push_frame();
      pulse();
      wait_idle();

      // Checksum-relevant patterns (also exercise plain streaming when disabled)
      pat_vec();
      push_frame();
      pulse();
      wait_idle();
      vec[0] = 32'h0000FFFF;
      push_frame();
      pulse();
      wait_idle();

      step(3);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/feature_vector_serializer.md
Name: feature_vector_serializer

Overview:
- Downstream consumer of the feature-extraction stage.
- Captures the 27-feature vector (5 PSD bands, peak amplitude, zero-crossing count, 20 DWT statistics) on the rising edge of that stage's valid.
- Streams the vector as 32-bit words over a valid/ready interface to the classifier, one word per accepted beat, tagged with index and frame ID.
- Flags frames lost because the previous vector was still draining.

Parameters:
- FRAME_ID_W, 8, width of the wrapping frame counter carried on out_frame_id.
- NUM_FEATURES, 27, words per frame. Fixed; any other value is illegal.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable.
- feat_valid  in  1  level valid from feature extraction. Vector is stable while high.
- psd_delta, psd_theta, psd_alpha, psd_beta, psd_gamma  in  32 each  signed band powers.
- peak_amplitude  in  32  signed.
- zero_counter  in  8  unsigned.
- dwt_{delta,theta,alpha,beta,gamma}_{max,min,mean,sum}  in  32 each  signed (20 ports).
- out_data  out  32  current word.
- out_index  out  5  word index within the frame.
- out_frame_id  out  FRAME_ID_W  frame number.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts.
- out_last  out  1  final word of the frame.
- busy  out  1  frame held or streaming.
- overrun  out  1  sticky: a vector arrived while busy.

Behaviour:
- Reset values: all outputs 0; state IDLE; feat_valid_d 0; frame counter 0.
- Edge detect: capture event = feat_valid & ~feat_valid_d & en. feat_valid_d is registered every cycle regardless of en.
- Word order:
  - 0..4: psd_delta, psd_theta, psd_alpha, psd_beta, psd_gamma.
  - 5: peak_amplitude.
  - 6: zero_counter, zero-extended to 32 bits.
  - 7..26: DWT in band order delta, theta, alpha, beta, gamma; within each band max, min, mean, sum (7 = dwt_delta_max, 26 = dwt_gamma_sum).
- State machine: IDLE / STREAM.
- IDLE:
  - On a capture event at cycle N, all words are latched into a register bank at the end of N.
  - out_valid = 1, out_index = 0, busy = 1 from cycle N+1. Latency is 1 cycle.
- STREAM:
  - A beat transfers when out_valid & out_ready.
  - On transfer, index increments and the next word is presented the following cycle. No bubbles while out_ready stays high, so a frame takes 27 cycles minimum.
  - out_data, out_index, out_frame_id and out_last hold stable while out_valid & ~out_ready.
  - out_last = 1 only when index = last word.
  - Transfer of the last word: return to IDLE, out_valid = 0, busy = 0, frame counter +1 (wraps modulo 2^FRAME_ID_W).
- Simultaneous last-beat transfer and capture event in the same cycle: the capture is accepted (bank reloads), index 0 of the new frame is presented next cycle, and overrun is not set.
- Capture event while in STREAM (excluding the last-beat case above): the new vector is dropped, overrun is set to 1 and stays set until rst, and the current frame continues unaffected.
- en = 0:
  - In IDLE, no capture.
  - In STREAM, the frame aborts: next cycle out_valid = 0, busy = 0, state IDLE, frame counter not incremented.
- rst mid-frame: all state and outputs return to reset values next cycle; the partial frame is discarded.
- No arithmetic on features; words pass bit-exact.

Optional Feature:
- Macro FEATURE_CHECKSUM_EN.
- When defined:
  - Frame is 28 words. Word 27 = bitwise XOR of words 0..26, computed combinationally from the captured bank.
  - out_last asserts on index 27; index 27 is the transition point for the simultaneous last-beat/capture case.
  - Minimum frame length is 28 cycles.
- When undefined:
  - Frame is 27 words, out_last on index 26.
  - No checksum logic is instantiated.

Test Plan:
- Basic capture: set each word k = k+1, zero_counter = 7, raise feat_valid at cycle N with out_ready = 1.
  - out_valid rises at N+1 and the 27 words stream back-to-back with out_index 0..26.
  - Word 6 = 0x00000007; out_last only at index 26; out_frame_id = 0; busy drops after the last beat.
- Backpressure: toggle out_ready every cycle.
  - Each word is held until accepted; no word is duplicated or skipped; the frame completes in 54 cycles.
- Overrun: raise a second feat_valid edge at index 10.
  - The current frame completes unchanged, overrun = 1 sticky, no second frame is emitted.
  - A later edge after IDLE produces frame_id = 1.
- Edge coincidence and wrap: hold out_ready = 1 and place a capture edge on the last-beat cycle for 256 consecutive frames with FRAME_ID_W = 8.
  - overrun stays 0, frame IDs run 0..255 then 0.
- Abort and reset:
  - Drop en at index 5: out_valid = 0 next cycle and frame_id is not incremented.
  - Assert rst at index 12: all outputs = 0 next cycle and overrun is cleared.
- FEATURE_CHECKSUM_EN: words k+1 for k = 0..26.
  - Index 27 = 0x00000000 (XOR of 1..27); out_last at index 27.
  - Change word 0 to 0x0000FFFF: index 27 = 0x0000FFFE.
